// File: rtl/iob_rr_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : iob_rr_arbiter_pkg                                             |
// | Purpose : Shared state encodings and types for the IOb round-robin       |
// |           arbiter and its helpers.                                       |
// | Ports   : none (package)                                                 |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package iob_rr_arbiter_pkg;

  // Controller state encoding (2-bit, values fixed for compatibility with
  // software that reads the state through debug taps).
  localparam int ST_W = 2;
  typedef logic [ST_W-1:0] state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Width of a counter that must hold values 0 .. max_val-1 (at least 1 bit).
  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/iob_reg_re.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : iob_reg_re                                                     |
// | Purpose : Generic register with asynchronous active-low reset, clock     |
// |           enable and load enable.                                        |
// | Ports   : clk_i   clock                                                  |
// |           cke_i   clock enable (no update when 0)                        |
// |           arst_i  asynchronous reset, active-low                         |
// |           en_i    load enable                                            |
// |           data_i  next value                                             |
// |           data_o  registered value                                       |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module iob_reg_re #(
  parameter int                DATA_W  = 1,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              arst_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      data_q <= RST_VAL;
    end else if (cke_i && en_i) begin
      data_q <= data_i;
    end
  end

  assign data_o = data_q;

endmodule
`default_nettype wire

// File: rtl/iob_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : iob_rr_pick                                                    |
// | Purpose : Combinational rotating-priority picker. Returns the first      |
// |           requester found scanning ptr, ptr+1, ... modulo N.             |
// | Ports   : req_i     N-bit request vector                                 |
// |           ptr_i     scan start index                                     |
// |           onehot_o  one-hot winner (all-zero if no request)              |
// |           idx_o     winner index (0 if no request)                       |
// |           any_o     1 when any request is present                        |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module iob_rr_pick #(
  parameter int N  = 2,
  parameter int NB = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [NB-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic [NB-1:0] idx_o,
  output logic          any_o
);

  logic [NB-1:0] w_pos;
  logic          w_found;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    w_found  = 1'b0;
    w_pos    = '0;
    for (int k = 0; k < N; k++) begin
      // Position k steps after the pointer, wrapped into 0..N-1.
      w_pos = NB'((int'(ptr_i) + k) % N);
      if (!w_found && req_i[w_pos]) begin
        onehot_o[w_pos] = 1'b1;
        idx_o           = w_pos;
        w_found         = 1'b1;
      end
    end
    any_o = w_found;
  end

endmodule
`default_nettype wire

// File: rtl/iob_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : iob_rr_arbiter                                                 |
// | Purpose : Round-robin arbiter in front of iob_merge. Selects one of N    |
// |           IOb masters, gates the other masters' avalids, keeps the       |
// |           grant while read responses are outstanding and limits burst    |
// |           length when other masters are waiting.                         |
// | Ports   : clk_i       clock                                              |
// |           cke_i       clock enable for every register                    |
// |           arst_i      asynchronous reset, active-low                     |
// |           m_avalid_i  raw master avalids [N]                             |
// |           m_avalid_o  gated avalids to iob_merge [N]                     |
// |           grant_o     one-hot owner, to iob_merge m_sel_src_i [N]        |
// |           f_wrt_i     forwarded request is a write                       |
// |           f_ready_i   follower ready                                     |
// |           f_rvalid_i  follower read response valid                       |
// |           busy_o      controller not idle or reads outstanding           |
// |           err_o       sticky: rvalid seen with no read outstanding       |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module iob_rr_arbiter
  import iob_rr_arbiter_pkg::*;
#(
  parameter int N         = 2,
  parameter int MAX_BURST = 4,
  parameter int MAX_RD    = 4,
  parameter int CNT_W     = $clog2(MAX_RD + 1),
  parameter int NB        = $clog2(N)
) (
  input  logic         clk_i,
  input  logic         cke_i,
  input  logic         arst_i,
  input  logic [N-1:0] m_avalid_i,
  output logic [N-1:0] m_avalid_o,
  output logic [N-1:0] grant_o,
  input  logic         f_wrt_i,
  input  logic         f_ready_i,
  input  logic         f_rvalid_i,
  output logic         busy_o,
  output logic         err_o
);

  localparam int BW = cnt_width(MAX_BURST);

  // Register state
  state_t           state_q,     state_d;
  logic [N-1:0]     grant_q,     grant_d;
  logic [NB-1:0]    owner_q,     owner_d;
  logic [NB-1:0]    ptr_q,       ptr_d;
  logic [CNT_W-1:0] rd_cnt_q,    rd_cnt_d;
  logic [BW-1:0]    burst_cnt_q, burst_cnt_d;
  logic             err_q,       err_d;

  // Combinational helpers
  logic [NB-1:0]    w_ptr_next;
  logic [NB-1:0]    w_pick_ptr;
  logic [N-1:0]     w_pick_onehot;
  logic [NB-1:0]    w_pick_idx;
  logic             w_pick_any;
  logic             w_rd_room;
  logic             w_acc;
  logic             w_owner_req;
  logic             w_others_req;
  logic             w_burst_last;
  logic             w_rd_inc;
  logic             w_rd_dec;

  // Pointer that the next arbitration starts from once the current owner
  // has released: the master just after the owner.
  assign w_ptr_next = (owner_q == NB'(N - 1)) ? '0 : owner_q + NB'(1);

  // In DRAIN the re-arbitration must already use the advanced pointer, in
  // the same cycle that the pointer register is updated.
  assign w_pick_ptr = (state_q == ST_DRAIN) ? w_ptr_next : ptr_q;

  iob_rr_pick #(
    .N  (N),
    .NB (NB)
  ) u_pick (
    .req_i    (m_avalid_i),
    .ptr_i    (w_pick_ptr),
    .onehot_o (w_pick_onehot),
    .idx_o    (w_pick_idx),
    .any_o    (w_pick_any)
  );

  assign w_rd_room    = (rd_cnt_q < CNT_W'(MAX_RD));
  assign m_avalid_o   = (state_q == ST_GRANT) ? (grant_q & m_avalid_i & {N{w_rd_room}}) : '0;
  // Only the owner's bit of m_avalid_o can be set, so OR-reduce is enough.
  assign w_acc        = (|m_avalid_o) & f_ready_i;
  assign w_owner_req  = |(m_avalid_i & grant_q);
  assign w_others_req = |(m_avalid_i & ~grant_q);
  assign w_burst_last = (burst_cnt_q == BW'(MAX_BURST - 1));

  // Outstanding-read accounting. Writes complete on acceptance and are
  // never counted.
  assign w_rd_inc = w_acc & ~f_wrt_i;
  assign w_rd_dec = f_rvalid_i;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    if (w_rd_inc && !w_rd_dec) begin
      rd_cnt_d = rd_cnt_q + CNT_W'(1);
    end else if (!w_rd_inc && w_rd_dec && (rd_cnt_q != '0)) begin
      rd_cnt_d = rd_cnt_q - CNT_W'(1);
    end
  end

  // A response with nothing outstanding is a protocol violation; it is
  // remembered until reset.
  assign err_d = err_q | (f_rvalid_i & (rd_cnt_q == '0));

  // Ownership control
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    burst_cnt_d = burst_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (w_pick_any) begin
          grant_d     = w_pick_onehot;
          owner_d     = w_pick_idx;
          burst_cnt_d = '0;
          state_d     = ST_GRANT;
        end
      end

      ST_GRANT: begin
        if (w_acc) begin
          burst_cnt_d = w_burst_last ? '0 : burst_cnt_q + BW'(1);
        end
        // Leaving is only possible when the owner is not presenting a
        // stalled request: either it dropped avalid, or its last burst
        // request was just accepted.
        if (!w_owner_req) begin
          state_d = ST_DRAIN;
        end else if (w_acc && w_burst_last && w_others_req) begin
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        // Grant is held until every read response has returned so that
        // iob_merge routes the responses back to the right master.
        if (rd_cnt_q == '0) begin
          ptr_d = w_ptr_next;
          if (w_pick_any) begin
            grant_d     = w_pick_onehot;
            owner_d     = w_pick_idx;
            burst_cnt_d = '0;
            state_d     = ST_GRANT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registers
  iob_reg_re #(.DATA_W(ST_W), .RST_VAL(ST_IDLE)) u_state_reg (
    .clk_i (clk_i), .cke_i (cke_i), .arst_i (arst_i), .en_i (1'b1),
    .data_i (state_d), .data_o (state_q)
  );

  iob_reg_re #(.DATA_W(N), .RST_VAL({{(N-1){1'b0}}, 1'b1})) u_grant_reg (
    .clk_i (clk_i), .cke_i (cke_i), .arst_i (arst_i), .en_i (1'b1),
    .data_i (grant_d), .data_o (grant_q)
  );

  iob_reg_re #(.DATA_W(NB), .RST_VAL('0)) u_owner_reg (
    .clk_i (clk_i), .cke_i (cke_i), .arst_i (arst_i), .en_i (1'b1),
    .data_i (owner_d), .data_o (owner_q)
  );

  iob_reg_re #(.DATA_W(NB), .RST_VAL('0)) u_ptr_reg (
    .clk_i (clk_i), .cke_i (cke_i), .arst_i (arst_i), .en_i (1'b1),
    .data_i (ptr_d), .data_o (ptr_q)
  );

  iob_reg_re #(.DATA_W(CNT_W), .RST_VAL('0)) u_rd_cnt_reg (
    .clk_i (clk_i), .cke_i (cke_i), .arst_i (arst_i), .en_i (1'b1),
    .data_i (rd_cnt_d), .data_o (rd_cnt_q)
  );

  iob_reg_re #(.DATA_W(BW), .RST_VAL('0)) u_burst_cnt_reg (
    .clk_i (clk_i), .cke_i (cke_i), .arst_i (arst_i), .en_i (1'b1),
    .data_i (burst_cnt_d), .data_o (burst_cnt_q)
  );

  iob_reg_re #(.DATA_W(1), .RST_VAL(1'b0)) u_err_reg (
    .clk_i (clk_i), .cke_i (cke_i), .arst_i (arst_i), .en_i (1'b1),
    .data_i (err_d), .data_o (err_q)
  );

  assign grant_o = grant_q;
  assign err_o   = err_q;
  assign busy_o  = (state_q != ST_IDLE) | (rd_cnt_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_iob_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_iob_rr_arbiter                                              |
// | Purpose : Self-checking bench for iob_rr_arbiter (N=2, MAX_BURST=4,      |
// |           MAX_RD=4): vector table, directed corner sequences and a       |
// |           randomized run against a reference model.                      |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_iob_rr_arbiter;

  localparam int N         = 2;
  localparam int MAX_BURST = 4;
  localparam int MAX_RD    = 4;

  logic         clk = 1'b0;
  logic         cke;
  logic         arst_n;
  logic [N-1:0] req;
  logic         rdy;
  logic         wrt;
  logic         rv;
  logic [N-1:0] mav;
  logic [N-1:0] gnt;
  logic         busy;
  logic         err;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  iob_rr_arbiter #(
    .N         (N),
    .MAX_BURST (MAX_BURST),
    .MAX_RD    (MAX_RD)
  ) dut (
    .clk_i      (clk),
    .cke_i      (cke),
    .arst_i     (arst_n),
    .m_avalid_i (req),
    .m_avalid_o (mav),
    .grant_o    (gnt),
    .f_wrt_i    (wrt),
    .f_ready_i  (rdy),
    .f_rvalid_i (rv),
    .busy_o     (busy),
    .err_o      (err)
  );

  // ---------------------------------------------------------------- checks
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic chk_all(input string name, input logic [N-1:0] eg, input logic [N-1:0] em,
                         input logic eb, input logic ee);
    chk({name, ".grant"},  32'(gnt),  32'(eg));
    chk({name, ".avalid"}, 32'(mav),  32'(em));
    chk({name, ".busy"},   32'(busy), 32'(eb));
    chk({name, ".err"},    32'(err),  32'(ee));
  endtask

  // Apply inputs just after the falling edge, settle, then sample.
  task automatic step(input logic [N-1:0] r, input logic rd, input logic wr, input logic v);
    @(negedge clk);
    req = r; rdy = rd; wrt = wr; rv = v;
    #1;
  endtask

  // ------------------------------------------------------- reference model
  typedef enum int {P_IDLE, P_GRANT, P_DRAIN} phase_t;
  phase_t m_ph;
  int     m_owner;
  int     m_ptr;
  int     m_burst;
  int     m_rd[$];   // one entry per outstanding read, tagged with its master
  bit     m_err;

  task automatic model_reset();
    m_ph = P_IDLE; m_owner = 0; m_ptr = 0; m_burst = 0; m_rd.delete(); m_err = 1'b0;
  endtask

  function automatic int first_from(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      if (r[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  function automatic bit model_gate();
    return (m_ph == P_GRANT) && req[m_owner] && (m_rd.size() < MAX_RD);
  endfunction

  task automatic model_check(input string name);
    logic [N-1:0] eg;
    logic [N-1:0] em;
    eg = '0;
    eg[m_owner] = 1'b1;
    em = model_gate() ? eg : '0;
    chk_all(name, eg, em, (m_ph != P_IDLE) || (m_rd.size() != 0), m_err);
  endtask

  task automatic model_clock();
    bit acc;
    int outstanding;
    logic [N-1:0] own;
    acc         = model_gate() && rdy;
    outstanding = m_rd.size();
    own         = '0;
    own[m_owner] = 1'b1;
    if (rv && outstanding == 0) m_err = 1'b1;
    if (acc && !wrt && !rv) m_rd.push_back(m_owner);
    else if (rv && !(acc && !wrt) && outstanding > 0) void'(m_rd.pop_front());
    case (m_ph)
      P_IDLE: if (req != 0) begin
        m_owner = first_from(req, m_ptr); m_burst = 0; m_ph = P_GRANT;
      end
      P_GRANT: begin
        if (!req[m_owner]) m_ph = P_DRAIN;
        else if (acc && m_burst == MAX_BURST - 1 && (req & ~own) != 0) m_ph = P_DRAIN;
        if (acc) m_burst = (m_burst + 1) % MAX_BURST;
      end
      default: if (outstanding == 0) begin
        m_ptr = (m_owner + 1) % N;
        if (req != 0) begin
          m_owner = first_from(req, m_ptr); m_burst = 0; m_ph = P_GRANT;
        end else begin
          m_ph = P_IDLE;
        end
      end
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    arst_n = 1'b0; req = '0; rdy = 1'b0; wrt = 1'b0; rv = 1'b0; cke = 1'b1;
    model_reset();
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  // --------------------------------------------------------- vector table
  typedef struct {
    logic [N-1:0] r;
    logic         rd, wr, v;
    logic [N-1:0] eg, em;
    logic         eb, ee;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [N-1:0] r, input logic rd, input logic wr, input logic v,
                     input logic [N-1:0] eg, input logic [N-1:0] em, input logic eb, input logic ee);
    vec_t e;
    e.r = r; e.rd = rd; e.wr = wr; e.v = v; e.eg = eg; e.em = em; e.eb = eb; e.ee = ee;
    tbl.push_back(e);
  endtask

  initial begin
    arst_n = 1'b0; cke = 1'b1; req = '0; rdy = 1'b0; wrt = 1'b0; rv = 1'b0;

    // Single read by m0, then fairness with both masters writing.
    add(2'b00, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0); // reset state
    add(2'b01, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0); // request seen in IDLE
    add(2'b01, 1'b1, 1'b0, 1'b0, 2'b01, 2'b01, 1'b1, 1'b0); // read accepted
    add(2'b00, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0); // m0 drops -> DRAIN
    add(2'b00, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 1'b1, 1'b0); // response returns
    add(2'b00, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0); // DRAIN sees 0 -> IDLE, ptr=1
    add(2'b00, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0);
    add(2'b11, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0); // ptr=1 -> m1 wins
    for (int i = 0; i < 4; i++) add(2'b11, 1'b1, 1'b1, 1'b0, 2'b10, 2'b10, 1'b1, 1'b0);
    add(2'b11, 1'b1, 1'b1, 1'b0, 2'b10, 2'b00, 1'b1, 1'b0); // DRAIN gap
    for (int i = 0; i < 4; i++) add(2'b11, 1'b1, 1'b1, 1'b0, 2'b01, 2'b01, 1'b1, 1'b0);
    add(2'b11, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0); // DRAIN gap
    add(2'b11, 1'b1, 1'b1, 1'b0, 2'b10, 2'b10, 1'b1, 1'b0);
    add(2'b00, 1'b1, 1'b1, 1'b0, 2'b10, 2'b00, 1'b1, 1'b0); // -> DRAIN
    add(2'b00, 1'b1, 1'b1, 1'b0, 2'b10, 2'b00, 1'b1, 1'b0); // -> IDLE
    add(2'b00, 1'b1, 1'b1, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0); // grant held in IDLE

    do_reset();
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].rd, tbl[i].wr, tbl[i].v);
      chk_all($sformatf("vec%0d", i), tbl[i].eg, tbl[i].em, tbl[i].eb, tbl[i].ee);
    end

    // Simultaneous requests right after reset: master 0 first.
    do_reset();
    step(2'b11, 1'b1, 1'b1, 1'b0);
    chk("prio.idle_avalid", 32'(mav), 32'(2'b00));
    step(2'b11, 1'b1, 1'b1, 1'b0);
    chk("prio.grant", 32'(gnt), 32'(2'b01));
    chk("prio.avalid", 32'(mav), 32'(2'b01));

    // Read-depth stall: four reads fill the tracker, fifth waits.
    do_reset();
    step(2'b01, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(2'b01, 1'b1, 1'b0, 1'b0);
      chk($sformatf("stall.rd%0d", i), 32'(mav), 32'(2'b01));
    end
    for (int i = 0; i < 2; i++) begin
      step(2'b01, 1'b1, 1'b0, 1'b0);
      chk("stall.blocked", 32'(mav), 32'(2'b00));
      chk("stall.grant", 32'(gnt), 32'(2'b01));
    end
    step(2'b01, 1'b1, 1'b0, 1'b1);
    chk("stall.rvalid_cycle", 32'(mav), 32'(2'b00));
    step(2'b01, 1'b1, 1'b0, 1'b0);
    chk("stall.reenabled", 32'(mav), 32'(2'b01));
    chk("stall.grant_end", 32'(gnt), 32'(2'b01));

    // Owner release with reads in flight: grant held until the counter,
    // as registered, reads zero.
    do_reset();
    step(2'b10, 1'b1, 1'b0, 1'b0);
    step(2'b10, 1'b1, 1'b0, 1'b0);
    chk("drain.m1_grant", 32'(gnt), 32'(2'b10));
    step(2'b10, 1'b1, 1'b0, 1'b0);
    step(2'b01, 1'b1, 1'b0, 1'b0);
    chk("drain.released", 32'(mav), 32'(2'b00));
    step(2'b01, 1'b1, 1'b0, 1'b1);
    chk("drain.hold1", 32'(gnt), 32'(2'b10));
    step(2'b01, 1'b1, 1'b0, 1'b1);
    chk("drain.hold2", 32'(gnt), 32'(2'b10));
    step(2'b01, 1'b1, 1'b0, 1'b0);
    chk("drain.hold3", 32'(gnt), 32'(2'b10));
    chk("drain.busy", 32'(busy), 32'(1'b1));
    step(2'b01, 1'b1, 1'b1, 1'b0);
    chk("drain.m0_grant", 32'(gnt), 32'(2'b01));
    chk("drain.m0_avalid", 32'(mav), 32'(2'b01));
    chk("drain.no_err", 32'(err), 32'(1'b0));

    // Error path and asynchronous reset in the middle of a grant.
    do_reset();
    step(2'b00, 1'b0, 1'b0, 1'b1);
    chk("err.before", 32'(err), 32'(1'b0));
    step(2'b00, 1'b0, 1'b0, 1'b0);
    chk("err.set", 32'(err), 32'(1'b1));
    chk("err.busy", 32'(busy), 32'(1'b0));
    step(2'b01, 1'b0, 1'b0, 1'b0);
    step(2'b01, 1'b0, 1'b0, 1'b0);
    chk("err.sticky", 32'(err), 32'(1'b1));
    chk("err.grant_avalid", 32'(mav), 32'(2'b01));
    #2 arst_n = 1'b0;
    #1;
    chk_all("areset", 2'b01, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    arst_n = 1'b1;

    // Randomized run against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      @(negedge clk);
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(3) == 0) req[b] = ~req[b];
      end
      rdy = ($urandom_range(3) != 0);
      wrt = 1'($urandom_range(1));
      rv  = (m_rd.size() > 0) ? ($urandom_range(2) == 0) : ($urandom_range(199) == 0);
      cke = ($urandom_range(7) != 0);
      #1;
      model_check($sformatf("rand%0d", i));
      @(posedge clk);
      if (cke) model_clock();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
